hazard3_ahbl_arb2: RTL and testbench

// 2-master to 1-slave AHB-Lite arbiter that shares one memory/bus port between the Hazard3 fetch (I) and load/store (D) ports.

---
 rtl/hazard3_ahbl_arb2.sv | 185 ++++++++++++++++++
 tb/tb_hazard3_ahbl_arb2.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_ahbl_arb2.sv
// 2-master, 1-slave AHB-Lite arbiter. Uncontested requests pass straight
// through. A losing address phase is captured into a per-master holding buffer
// and replayed to the slave later, with the master stalled until it completes.
// m0 = load/store port, m1 = fetch port.

module hazard3_ahbl_arb2 #(
   parameter int W_ADDR         = 32,
   parameter int W_DATA         = 32,
   parameter int FIXED_PRIORITY = 1
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic [W_ADDR-1:0] m0_haddr,
   input  logic              m0_hwrite,
   input  logic [1:0]        m0_htrans,
   input  logic [2:0]        m0_hsize,
   input  logic [3:0]        m0_hprot,
   input  logic              m0_hexcl,
   input  logic [W_DATA-1:0] m0_hwdata,
   output logic              m0_hready,
   output logic              m0_hresp,
   output logic              m0_hexokay,
   output logic [W_DATA-1:0] m0_hrdata,

   input  logic [W_ADDR-1:0] m1_haddr,
   input  logic              m1_hwrite,
   input  logic [1:0]        m1_htrans,
   input  logic [2:0]        m1_hsize,
   input  logic [3:0]        m1_hprot,
   input  logic              m1_hexcl,
   input  logic [W_DATA-1:0] m1_hwdata,
   output logic              m1_hready,
   output logic              m1_hresp,
   output logic              m1_hexokay,
   output logic [W_DATA-1:0] m1_hrdata,

   output logic [W_ADDR-1:0] s_haddr,
   output logic              s_hwrite,
   output logic [1:0]        s_htrans,
   output logic [2:0]        s_hsize,
   output logic [3:0]        s_hprot,
   output logic              s_hexcl,
   output logic [W_DATA-1:0] s_hwdata,
   input  logic              s_hready,
   input  logic              s_hresp,
   input  logic              s_hexokay,
   input  logic [W_DATA-1:0] s_hrdata
);

   typedef struct packed {
      logic [W_ADDR-1:0] addr;
      logic              write;
      logic [1:0]        trans;
      logic [2:0]        size;
      logic [3:0]        prot;
      logic              excl;
   } aph_t;

   typedef enum logic [1:0] {
      DPH_NONE = 2'd0,
      DPH_M0   = 2'd1,
      DPH_M1   = 2'd2
   } dph_t;

   dph_t       dph_owner;
   logic       rr_last;
   logic [1:0] buf_vld;
   aph_t       buf_aph [2];
   aph_t       hold_aph;

   logic [1:0] hready_base;
   logic [1:0] live;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] capture;
   aph_t       live_aph [2];
   aph_t       src_aph  [2];
   aph_t       gnt_aph;

   // Request sources: live bus only counts when the master sees ready; the
   // raw ready (without capture hold) is used to avoid a loop through hready.
   always_comb begin
      live_aph[0]    = '{addr: m0_haddr, write: m0_hwrite, trans: m0_htrans,
                         size: m0_hsize, prot: m0_hprot, excl: m0_hexcl};
      live_aph[1]    = '{addr: m1_haddr, write: m1_hwrite, trans: m1_htrans,
                         size: m1_hsize, prot: m1_hprot, excl: m1_hexcl};
      hready_base[0] = (dph_owner == DPH_M0) ? s_hready : !buf_vld[0];
      hready_base[1] = (dph_owner == DPH_M1) ? s_hready : !buf_vld[1];
      live[0]        = m0_htrans[1] & hready_base[0];
      live[1]        = m1_htrans[1] & hready_base[1];
      req            = buf_vld | live;
      src_aph[0]     = buf_vld[0] ? buf_aph[0] : live_aph[0];
      src_aph[1]     = buf_vld[1] ? buf_aph[1] : live_aph[1];
   end

   // Grant: only while the slave can accept a new address phase
   always_comb begin
      gnt = 2'b00;
      if (s_hready) begin
         if (req == 2'b11) begin
            if (FIXED_PRIORITY != 0 || rr_last)
               gnt = 2'b01;
            else
               gnt = 2'b10;
         end else begin
            gnt = req;
         end
      end
      capture = live & ~gnt;
   end

   // Slave address phase: granted source, else IDLE with the last address held
   always_comb begin
      gnt_aph  = gnt[1] ? src_aph[1] : src_aph[0];
      s_haddr  = hold_aph.addr;
      s_hwrite = hold_aph.write;
      s_htrans = 2'b00;
      s_hsize  = hold_aph.size;
      s_hprot  = hold_aph.prot;
      s_hexcl  = hold_aph.excl;
      if (|gnt) begin
         s_haddr  = gnt_aph.addr;
         s_hwrite = gnt_aph.write;
         s_htrans = gnt_aph.trans;
         s_hsize  = gnt_aph.size;
         s_hprot  = gnt_aph.prot;
         s_hexcl  = gnt_aph.excl;
      end
   end

   // Master-side response routing and data-phase write data mux
   always_comb begin
      m0_hready  = hready_base[0] & ~capture[0];
      m1_hready  = hready_base[1] & ~capture[1];
      m0_hresp   = (dph_owner == DPH_M0) & s_hresp;
      m1_hresp   = (dph_owner == DPH_M1) & s_hresp;
      m0_hexokay = (dph_owner == DPH_M0) & s_hexokay;
      m1_hexokay = (dph_owner == DPH_M1) & s_hexokay;
      m0_hrdata  = s_hrdata;
      m1_hrdata  = s_hrdata;
      case (dph_owner)
         DPH_M0:  s_hwdata = m0_hwdata;
         DPH_M1:  s_hwdata = m1_hwdata;
         default: s_hwdata = '0;
      endcase
   end

   // Holding buffers: capture a losing live request, drop it once replayed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld <= 2'b00;
         for (int n = 0; n < 2; n++) buf_aph[n] <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (capture[n]) begin
               buf_vld[n] <= 1'b1;
               buf_aph[n] <= live_aph[n];
            end else if (gnt[n]) begin
               buf_vld[n] <= 1'b0;
            end
         end
      end
   end

   // Arbitration state: data-phase owner, round-robin pointer, held address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_owner <= DPH_NONE;
         rr_last   <= 1'b1;
         hold_aph  <= '0;
      end else begin
         if (s_hready) begin
            if (gnt[0])      dph_owner <= DPH_M0;
            else if (gnt[1]) dph_owner <= DPH_M1;
            else             dph_owner <= DPH_NONE;
         end
         if (|gnt) begin
            rr_last  <= gnt[1];
            hold_aph <= gnt_aph;
         end
      end
   end

endmodule

// File: tb/tb_hazard3_ahbl_arb2.sv
// Directed bench for hazard3_ahbl_arb2. A fixed-priority and a round-robin
// instance share the same stimulus; slave address phases are checked against
// per-instance queues of expected addresses.

module tb_hazard3_ahbl_arb2;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
   logic        m0_hwrite, m1_hwrite, m0_hexcl, m1_hexcl;
   logic [1:0]  m0_htrans, m1_htrans;
   logic [2:0]  m0_hsize, m1_hsize;
   logic [3:0]  m0_hprot, m1_hprot;
   logic        s_hready, s_hresp, s_hexokay;
   logic [31:0] s_hrdata;

   logic        m0_hready, m0_hresp, m0_hexokay, m1_hready, m1_hresp, m1_hexokay;
   logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
   logic        s_hwrite, s_hexcl;
   logic [1:0]  s_htrans;
   logic [2:0]  s_hsize;
   logic [3:0]  s_hprot;

   logic        r_m0_hready, r_m0_hresp, r_m0_hexokay, r_m1_hready, r_m1_hresp, r_m1_hexokay;
   logic [31:0] r_m0_hrdata, r_m1_hrdata, r_s_haddr, r_s_hwdata;
   logic        r_s_hwrite, r_s_hexcl;
   logic [1:0]  r_s_htrans;
   logic [2:0]  r_s_hsize;
   logic [3:0]  r_s_hprot;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_rr_q[$];

   always #5 clk = ~clk;

   hazard3_ahbl_arb2 #(.FIXED_PRIORITY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
      .m0_hprot(m0_hprot), .m0_hexcl(m0_hexcl), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready),
      .m0_hresp(m0_hresp), .m0_hexokay(m0_hexokay), .m0_hrdata(m0_hrdata),
      .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
      .m1_hprot(m1_hprot), .m1_hexcl(m1_hexcl), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready),
      .m1_hresp(m1_hresp), .m1_hexokay(m1_hexokay), .m1_hrdata(m1_hrdata),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
      .s_hprot(s_hprot), .s_hexcl(s_hexcl), .s_hwdata(s_hwdata), .s_hready(s_hready),
      .s_hresp(s_hresp), .s_hexokay(s_hexokay), .s_hrdata(s_hrdata)
   );

   hazard3_ahbl_arb2 #(.FIXED_PRIORITY(0)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
      .m0_hprot(m0_hprot), .m0_hexcl(m0_hexcl), .m0_hwdata(m0_hwdata), .m0_hready(r_m0_hready),
      .m0_hresp(r_m0_hresp), .m0_hexokay(r_m0_hexokay), .m0_hrdata(r_m0_hrdata),
      .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
      .m1_hprot(m1_hprot), .m1_hexcl(m1_hexcl), .m1_hwdata(m1_hwdata), .m1_hready(r_m1_hready),
      .m1_hresp(r_m1_hresp), .m1_hexokay(r_m1_hexokay), .m1_hrdata(r_m1_hrdata),
      .s_haddr(r_s_haddr), .s_hwrite(r_s_hwrite), .s_htrans(r_s_htrans), .s_hsize(r_s_hsize),
      .s_hprot(r_s_hprot), .s_hexcl(r_s_hexcl), .s_hwdata(r_s_hwdata), .s_hready(s_hready),
      .s_hresp(s_hresp), .s_hexokay(s_hexokay), .s_hrdata(s_hrdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every active slave address phase must match the next expected one
   task automatic mon();
      logic [31:0] e;
      if (s_htrans[1]) begin
         chk("sb_fp_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_fp_addr", 64'(s_haddr), 64'(e));
         end
      end
      if (r_s_htrans[1]) begin
         chk("sb_rr_pending", 64'(exp_rr_q.size() != 0), 64'd1);
         if (exp_rr_q.size() != 0) begin
            e = exp_rr_q.pop_front();
            chk("sb_rr_addr", 64'(r_s_haddr), 64'(e));
         end
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back(a);
      exp_rr_q.push_back(a);
   endtask

   task automatic at_neg();
      @(negedge clk);
      mon();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_htrans = 2'b00; m1_htrans = 2'b00;
      m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
      m0_haddr  = '0;    m1_haddr  = '0;
      m0_hwdata = '0;    m1_hwdata = '0;
      s_hready  = 1'b1;  s_hresp   = 1'b0; s_hexokay = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_all();
      exp_q.delete();
      exp_rr_q.delete();
      to_pos();
      to_pos();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_all();
      m0_hsize = 3'd2; m1_hsize = 3'd2;
      m0_hprot = 4'h3; m1_hprot = 4'h3;
      m0_hexcl = 1'b0; m1_hexcl = 1'b0;
      s_hrdata = '0;

      // Reset state
      @(negedge clk);
      chk("rst_htrans",   64'(s_htrans), 64'd0);
      chk("rst_m0_ready", 64'(m0_hready), 64'd1);
      chk("rst_m1_ready", 64'(m1_hready), 64'd1);
      chk("rst_m0_resp",  64'(m0_hresp), 64'd0);
      chk("rst_m1_exok",  64'(m1_hexokay), 64'd0);
      to_pos();
      rst_n = 1'b1;

      // Lone m1 read: zero added latency
      m1_htrans = 2'b10; m1_haddr = 32'h100; push(32'h100);
      at_neg();
      chk("lone_htrans", 64'(s_htrans), 64'd2);
      chk("lone_ready_aph", 64'(m1_hready), 64'd1);
      to_pos();
      m1_htrans = 2'b00; s_hrdata = 32'hDEAD0100;
      at_neg();
      chk("lone_rdata", 64'(m1_hrdata), 64'hDEAD0100);
      chk("lone_ready_dph", 64'(m1_hready), 64'd1);
      chk("lone_resp", 64'(m1_hresp), 64'd0);
      to_pos();
      do_reset();

      // Simultaneous NSEQ: m0 first, m1 buffered and replayed
      m0_htrans = 2'b10; m0_haddr = 32'h10;
      m1_htrans = 2'b10; m1_haddr = 32'h20;
      push(32'h10); push(32'h20);
      at_neg();
      chk("tie_m0_ready", 64'(m0_hready), 64'd1);
      chk("tie_m1_ready_c0", 64'(m1_hready), 64'd0);
      to_pos();
      m0_htrans = 2'b00;
      at_neg();
      chk("tie_replay_addr", 64'(s_haddr), 64'h20);
      chk("tie_m1_ready_c1", 64'(m1_hready), 64'd0);
      to_pos();
      m1_htrans = 2'b00;
      at_neg();
      chk("tie_m1_ready_c2", 64'(m1_hready), 64'd1);
      chk("tie_idle_after", 64'(s_htrans), 64'd0);
      to_pos();
      do_reset();

      // Continuous requests from both: FP always m0, RR alternates
      m0_htrans = 2'b10; m0_haddr = 32'h40;
      m1_htrans = 2'b10; m1_haddr = 32'h80;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(32'h40);
         exp_rr_q.push_back((i % 2 == 0) ? 32'h40 : 32'h80);
         at_neg();
         chk("rr_active", 64'(r_s_htrans), 64'd2);
         to_pos();
      end
      chk("rr_sb_drained", 64'(exp_rr_q.size()), 64'd0);
      do_reset();

      // m0 write with slave wait states while m1 requests
      m0_htrans = 2'b10; m0_hwrite = 1'b1; m0_haddr = 32'h200; push(32'h200);
      at_neg();
      chk("wr_hwrite", 64'(s_hwrite), 64'd1);
      to_pos();
      m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hwdata = 32'hCAFEF00D;
      m1_htrans = 2'b10; m1_haddr = 32'h300; m1_hwdata = 32'h11112222;
      s_hready = 1'b0; push(32'h300);
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("wait_haddr", 64'(s_haddr), 64'h200);
         chk("wait_htrans", 64'(s_htrans), 64'd0);
         chk("wait_hwdata", 64'(s_hwdata), 64'hCAFEF00D);
         chk("wait_m0_ready", 64'(m0_hready), 64'd0);
         chk("wait_m1_ready", 64'(m1_hready), 64'd0);
         to_pos();
      end
      s_hready = 1'b1; s_hexokay = 1'b1;
      at_neg();
      chk("wr_done_m0_ready", 64'(m0_hready), 64'd1);
      chk("wr_done_hwdata", 64'(s_hwdata), 64'hCAFEF00D);
      chk("wr_m0_exokay", 64'(m0_hexokay), 64'd1);
      chk("wr_m1_exokay", 64'(m1_hexokay), 64'd0);
      chk("wr_m1_still_wait", 64'(m1_hready), 64'd0);
      to_pos();
      m1_htrans = 2'b00; s_hexokay = 1'b0; m0_hwdata = '0;
      at_neg();
      chk("m1_dph_ready", 64'(m1_hready), 64'd1);
      chk("m1_dph_hwdata", 64'(s_hwdata), 64'h11112222);
      to_pos();
      do_reset();

      // Two-cycle error response on m1 read
      m1_htrans = 2'b10; m1_haddr = 32'h180; push(32'h180);
      at_neg();
      to_pos();
      m1_htrans = 2'b00; s_hready = 1'b0; s_hresp = 1'b1;
      at_neg();
      chk("err1_m1_resp", 64'(m1_hresp), 64'd1);
      chk("err1_m1_ready", 64'(m1_hready), 64'd0);
      chk("err1_m0_resp", 64'(m0_hresp), 64'd0);
      to_pos();
      s_hready = 1'b1;
      at_neg();
      chk("err2_m1_resp", 64'(m1_hresp), 64'd1);
      chk("err2_m1_ready", 64'(m1_hready), 64'd1);
      chk("err2_m0_resp", 64'(m0_hresp), 64'd0);
      to_pos();
      s_hresp = 1'b0;
      at_neg();
      chk("err_done_resp", 64'(m1_hresp), 64'd0);
      to_pos();
      do_reset();

      // Reset asserted while m1 is buffered: the buffered request is discarded
      m0_htrans = 2'b10; m0_haddr = 32'h400;
      m1_htrans = 2'b10; m1_haddr = 32'h500;
      exp_q.push_back(32'h400); exp_rr_q.push_back(32'h400);
      at_neg();
      chk("rstmid_m1_buffered", 64'(m1_hready), 64'd0);
      #2;
      rst_n = 1'b0;
      m0_htrans = 2'b00; m1_htrans = 2'b00;
      #1;
      chk("rstmid_async_htrans", 64'(s_htrans), 64'd0);
      chk("rstmid_async_m0_ready", 64'(m0_hready), 64'd1);
      chk("rstmid_async_m1_ready", 64'(m1_hready), 64'd1);
      to_pos();
      at_neg();
      chk("rstmid_htrans", 64'(s_htrans), 64'd0);
      chk("rstmid_m1_ready", 64'(m1_hready), 64'd1);
      to_pos();
      rst_n = 1'b1;
      at_neg();
      chk("rstmid_no_replay", 64'(s_htrans), 64'd0);
      to_pos();
      at_neg();
      chk("rstmid_still_idle", 64'(s_htrans), 64'd0);

      chk("sb_fp_empty", 64'(exp_q.size()), 64'd0);
      chk("sb_rr_empty", 64'(exp_rr_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
